// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: host request and device response channel payloads.
package tlul_pkg;

   localparam logic [2:0] PutFullData   = 3'h0;
   localparam logic [2:0] Get           = 3'h4;
   localparam logic [2:0] AccessAck     = 3'h0;
   localparam logic [2:0] AccessAckData = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/student_dma_gen2.sv
// Descriptor-driven memset/memcpy DMA engine with a TL-UL host port.
// Optional macro STUDENT_DMA_CHAIN_EN: fetch a fifth next-pointer word and follow descriptor chains.
module student_dma_gen2 #(
   parameter int unsigned FifoDepth      = 8,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [31:0]       desc_addr_i,
   input  logic              stop_i,
   output logic [1:0]        status_o,
   output logic              done_o,
   output logic              err_o,
   output tlul_pkg::tl_h2d_t tl_host_o,
   input  tlul_pkg::tl_d2h_t tl_host_i
);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned SumW = CntW + 1;
   localparam int unsigned OutW = 4;
`ifdef STUDENT_DMA_CHAIN_EN
   localparam logic [2:0] LastWord = 3'd4;
`else
   localparam logic [2:0] LastWord = 3'd3;
`endif

   typedef enum logic [2:0] {IDLE, DESC_REQ, DESC_WAIT, MEMSET, MEMCPY, DRAIN} state_e;

   state_e state_q, state_d;
   logic [31:0] desc_ptr_q, desc_ptr_d, src_q, src_d, dst_q, dst_d;
   logic [29:0] nwords_q, nwords_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [2:0]  widx_q, widx_d;
   logic [OutW-1:0] out_q, out_d;
   logic [CntW-1:0] rd_out_q, rd_out_d, fifo_cnt_q, fifo_cnt_d;
   logic [PtrW-1:0] fifo_rptr_q, fifo_rptr_d, fifo_wptr_q, fifo_wptr_d;
   logic [31:0] fifo_mem_q [FifoDepth];
   logic [31:0] a_addr_q, a_addr_d, a_data_q, a_data_d;
   logic [1:0]  status_q, status_d;
   logic op_q, op_d, abort_q, abort_d, err_q, err_d, done_q, done_d;
   logic a_valid_q, a_valid_d, a_get_q, a_get_d;
`ifdef STUDENT_DMA_CHAIN_EN
   logic [31:0] next_q, next_d;
`endif

   logic fire, slot_free, resp, resp_data, resp_err, abort_req, can_issue;
   logic load, ld_get, rd_issue, rd_dec, push, pop, flush, fifo_we, complete;
   logic [31:0] ld_addr, ld_data;
   logic unused_tl;

   assign fire      = a_valid_q & tl_host_i.a_ready;
   assign slot_free = ~a_valid_q | tl_host_i.a_ready;
   // Responses are only meaningful while something is outstanding.
   assign resp      = tl_host_i.d_valid & (out_q != '0);
   assign resp_data = resp & (tl_host_i.d_opcode == tlul_pkg::AccessAckData);
   assign resp_err  = resp & tl_host_i.d_error;
   assign abort_req = stop_i | resp_err;
   assign can_issue = slot_free & (out_q < OutW'(MaxOutstanding));
   assign unused_tl = ^{tl_host_i.d_param, tl_host_i.d_size, tl_host_i.d_source, tl_host_i.d_sink};

   always_comb begin
      state_d = state_q;   desc_ptr_d = desc_ptr_q; src_d = src_q;   dst_d = dst_q;
      nwords_d = nwords_q; rd_cnt_d = rd_cnt_q;     wr_cnt_d = wr_cnt_q; widx_d = widx_q;
      op_d = op_q;         abort_d = abort_q;       err_d = err_q;   done_d = 1'b0;
      a_valid_d = a_valid_q; a_get_d = a_get_q; a_addr_d = a_addr_q; a_data_d = a_data_q;
`ifdef STUDENT_DMA_CHAIN_EN
      next_d = next_q;
`endif
      load = 1'b0; ld_get = 1'b0; ld_addr = '0; ld_data = '0;
      rd_issue = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; complete = 1'b0;

      if (fire) a_valid_d = 1'b0;
      if (resp_err) err_d = 1'b1;

      case (state_q)
         IDLE: if (start_i && !stop_i) begin
            state_d = DESC_REQ; desc_ptr_d = desc_addr_i; widx_d = '0;
            err_d = 1'b0; abort_d = 1'b0;
         end
         DESC_REQ: begin
            if (abort_req) begin
               state_d = DRAIN; abort_d = 1'b1;
            end else if (slot_free) begin
               load = 1'b1; ld_get = 1'b1;
               ld_addr = desc_ptr_q + {27'd0, widx_q, 2'b00};
               state_d = DESC_WAIT;
            end
         end
         DESC_WAIT: begin
            if (abort_req) begin
               state_d = DRAIN; abort_d = 1'b1;
            end else if (resp) begin
               case (widx_q)
                  3'd0: op_d = tl_host_i.d_data[0];
                  3'd1: nwords_d = tl_host_i.d_data[31:2];
                  3'd2: src_d = tl_host_i.d_data;
                  3'd3: dst_d = tl_host_i.d_data;
`ifdef STUDENT_DMA_CHAIN_EN
                  3'd4: next_d = tl_host_i.d_data;
`endif
                  default: ;
               endcase
               widx_d = widx_q + 3'd1;
               if (widx_q == LastWord) begin
                  rd_cnt_d = '0; wr_cnt_d = '0;
                  if (nwords_q == '0) complete = 1'b1;
                  else state_d = op_q ? MEMCPY : MEMSET;
               end else begin
                  state_d = DESC_REQ;
               end
            end
         end
         MEMSET: begin
            if (abort_req) begin
               state_d = DRAIN; abort_d = 1'b1;
            end else if (wr_cnt_q == nwords_q) begin
               state_d = DRAIN;
            end else if (can_issue) begin
               load = 1'b1; ld_addr = dst_q + {wr_cnt_q, 2'b00}; ld_data = src_q;
               wr_cnt_d = wr_cnt_q + 30'd1;
            end
         end
         MEMCPY: begin
            push = resp_data & ~resp_err;
            if (abort_req) begin
               state_d = DRAIN; abort_d = 1'b1; flush = 1'b1;
            end else if (wr_cnt_q == nwords_q) begin
               state_d = DRAIN;
            end else if (can_issue && fifo_cnt_q != '0) begin
               // Draining the FIFO takes priority over refilling it.
               load = 1'b1; pop = 1'b1;
               ld_addr = dst_q + {wr_cnt_q, 2'b00}; ld_data = fifo_mem_q[fifo_rptr_q];
               wr_cnt_d = wr_cnt_q + 30'd1;
            end else if (can_issue && rd_cnt_q < nwords_q &&
                         (SumW'(rd_out_q) + SumW'(fifo_cnt_q)) < SumW'(FifoDepth)) begin
               load = 1'b1; ld_get = 1'b1; rd_issue = 1'b1;
               ld_addr = src_q + {rd_cnt_q, 2'b00};
               rd_cnt_d = rd_cnt_q + 30'd1;
            end
         end
         DRAIN: begin
            if (resp_err) abort_d = 1'b1;
            if (out_q == '0 && fifo_cnt_q == '0) begin
               if (abort_q) state_d = IDLE;
               else complete = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
`ifdef STUDENT_DMA_CHAIN_EN
         if (next_d != 32'd0) begin
            state_d = DESC_REQ; desc_ptr_d = next_d; widx_d = '0;
         end else begin
            state_d = IDLE; done_d = 1'b1;
         end
`else
         state_d = IDLE; done_d = 1'b1;
`endif
      end

      if (load) begin
         a_valid_d = 1'b1; a_get_d = ld_get; a_addr_d = ld_addr; a_data_d = ld_data;
      end

      // Issue and response paths update the outstanding count independently.
      case ({load, resp})
         2'b10:   out_d = out_q + OutW'(1);
         2'b01:   out_d = out_q - OutW'(1);
         default: out_d = out_q;
      endcase
      rd_dec = resp_data & (rd_out_q != '0);
      case ({rd_issue, rd_dec})
         2'b10:   rd_out_d = rd_out_q + CntW'(1);
         2'b01:   rd_out_d = rd_out_q - CntW'(1);
         default: rd_out_d = rd_out_q;
      endcase

      fifo_we = push & ~flush;
      fifo_wptr_d = fifo_wptr_q; fifo_rptr_d = fifo_rptr_q; fifo_cnt_d = fifo_cnt_q;
      if (flush) begin
         fifo_wptr_d = '0; fifo_rptr_d = '0; fifo_cnt_d = '0;
      end else begin
         if (push) fifo_wptr_d = fifo_wptr_q + PtrW'(1);
         if (pop)  fifo_rptr_d = fifo_rptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
         endcase
      end

      case (state_d)
         DESC_REQ, DESC_WAIT: status_d = 2'd1;
         MEMSET:              status_d = 2'd2;
         MEMCPY:              status_d = 2'd3;
         DRAIN:               status_d = op_d ? 2'd3 : 2'd2;
         default:             status_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;  desc_ptr_q <= '0; src_q <= '0;  dst_q <= '0;
         nwords_q <= '0;   rd_cnt_q <= '0;   wr_cnt_q <= '0; widx_q <= '0;
         out_q <= '0;      rd_out_q <= '0;   fifo_cnt_q <= '0;
         fifo_rptr_q <= '0; fifo_wptr_q <= '0;
         a_addr_q <= '0;   a_data_q <= '0;   status_q <= '0;
         op_q <= 1'b0; abort_q <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
         a_valid_q <= 1'b0; a_get_q <= 1'b0;
`ifdef STUDENT_DMA_CHAIN_EN
         next_q <= '0;
`endif
         for (int i = 0; i < int'(FifoDepth); i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q <= state_d;   desc_ptr_q <= desc_ptr_d; src_q <= src_d; dst_q <= dst_d;
         nwords_q <= nwords_d; rd_cnt_q <= rd_cnt_d;     wr_cnt_q <= wr_cnt_d; widx_q <= widx_d;
         out_q <= out_d;       rd_out_q <= rd_out_d;     fifo_cnt_q <= fifo_cnt_d;
         fifo_rptr_q <= fifo_rptr_d; fifo_wptr_q <= fifo_wptr_d;
         a_addr_q <= a_addr_d; a_data_q <= a_data_d;     status_q <= status_d;
         op_q <= op_d; abort_q <= abort_d; err_q <= err_d; done_q <= done_d;
         a_valid_q <= a_valid_d; a_get_q <= a_get_d;
`ifdef STUDENT_DMA_CHAIN_EN
         next_q <= next_d;
`endif
         if (fifo_we) fifo_mem_q[fifo_wptr_q] <= tl_host_i.d_data;
      end
   end

   assign status_o = status_q;
   assign done_o   = done_q;
   assign err_o    = err_q;

   always_comb begin
      tl_host_o           = '0;
      tl_host_o.a_valid   = a_valid_q;
      tl_host_o.a_opcode  = a_get_q ? tlul_pkg::Get : tlul_pkg::PutFullData;
      tl_host_o.a_size    = 2'd2;
      tl_host_o.a_address = a_addr_q;
      tl_host_o.a_mask    = 4'hF;
      tl_host_o.a_data    = a_data_q;
      tl_host_o.d_ready   = 1'b1;
   end

endmodule

// File: doc/student_dma_gen2.md
STUDENT_DMA_GEN2 -- requirements
Module: student_dma_gen2

Interface
REQ-001 The block SHALL have parameter FifoDepth, default 8: memcpy buffer entries of 32 bits; power of two, at least 2.
REQ-002 The block SHALL have parameter MaxOutstanding, default 4: limit on unacknowledged TL-UL A-channel requests; range 1..15.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: single-cycle pulse that launches descriptor processing at desc_addr_i.
REQ-006 The block SHALL have port desc_addr_i, input, 32 bits: byte address of the first descriptor, sampled on an accepted start_i.
REQ-007 The block SHALL have port stop_i, input, 1 bit: single-cycle abort request.
REQ-008 The block SHALL have port status_o, output, 2 bits: 0 idle, 1 reading descriptor, 2 memset busy, 3 memcpy busy.
REQ-009 The block SHALL have port done_o, output, 1 bit: one-cycle pulse on normal completion of the last descriptor.
REQ-010 The block SHALL have port err_o, output, 1 bit: sticky flag for a d_error response; cleared by the next accepted start_i.
REQ-011 The block SHALL have port tl_host_o, output, tlul_pkg::tl_h2d_t: TL-UL host request channel.
REQ-012 The block SHALL have port tl_host_i, input, tlul_pkg::tl_d2h_t: TL-UL host response channel.

Function
REQ-013 Every request SHALL use: a_size 2, a_mask all ones, a_source 0, d_ready constantly 1; responses are in request order.
REQ-014 a_valid and all a_* fields SHALL hold stable from assertion until the cycle a_valid and a_ready are both high.
REQ-015 Descriptor layout SHALL be: word0 bit0 op (0 memset, 1 memcpy); word1 length in bytes, bits 1:0 ignored; word2 src address or memset pattern; word3 dst address; word4 next pointer (chain build only).
REQ-016 The FSM SHALL have states IDLE, DESC_REQ, DESC_WAIT, MEMSET, MEMCPY, DRAIN.
REQ-017 IDLE -> DESC_REQ SHALL occur on start_i when stop_i is low; start_i outside IDLE SHALL be ignored.
REQ-018 Descriptor fetch SHALL issue one Get per word, and each Get SHALL wait for its AccessAckData before the next is issued.
REQ-019 After the last word: length 0 -> completion; otherwise op selects MEMSET or MEMCPY.
REQ-020 MEMSET SHALL issue PutFullData with a_data = pattern at dst, dst+4, ..., limited by MaxOutstanding.
REQ-021 MEMCPY SHALL issue Get at src+4k only while (outstanding reads + FIFO occupancy) < FifoDepth, so FIFO overflow cannot occur.
REQ-022 MEMCPY SHALL write AccessAckData payloads to the FIFO, and SHALL issue PutFullData from the FIFO head at dst+4k.
REQ-023 When both a read and a write are eligible in MEMCPY, the write SHALL win.
REQ-024 The issued-request and response counters SHALL be independent; the state SHALL enter DRAIN when all requests are issued.
REQ-025 DRAIN SHALL leave when the outstanding count reaches 0 and the FIFO is empty.
REQ-026 Completion SHALL pulse done_o and return to IDLE the next cycle.
REQ-027 Address arithmetic SHALL wrap modulo 2^32.
REQ-028 On stop_i in any non-IDLE state, no new requests SHALL be issued, the FIFO SHALL be flushed, the block SHALL go to DRAIN until outstanding is 0, then IDLE without done_o; a pending a_valid SHALL still complete its handshake first.
REQ-029 A response with d_error SHALL set err_o and be treated as a stop.
REQ-030 If a response and a new issue occur in the same cycle, the outstanding count SHALL be unchanged.

Reset
REQ-031 While rst_ni is low: state IDLE, status_o 0, done_o 0, err_o 0, a_valid 0, FIFO empty, all counters and registers 0.
REQ-032 Reset asserted mid-transfer SHALL abandon outstanding responses; no recovery from them is attempted.

Configuration
REQ-033 With macro STUDENT_DMA_CHAIN_EN defined: word4 SHALL be fetched (five words), and after a descriptor completes a non-zero next pointer SHALL go to DESC_REQ at that address; done_o SHALL pulse only when next is 0.
REQ-034 With STUDENT_DMA_CHAIN_EN undefined: four words SHALL be fetched and done_o SHALL pulse after each descriptor.

Verification
REQ-035 Memset {op0, len 16, pattern 0xA5A5A5A5, dst 0x100}, a_ready always 1 -> 4 PutFullData to 0x100..0x10C with data 0xA5A5A5A5, done_o once, status_o 2 then 0.
REQ-036 Memcpy len 64, FifoDepth 8, device responses delayed 10 cycles -> 16 words copied in order; outstanding never exceeds 4; FIFO never overflows.
REQ-037 a_ready randomly low 50% -> a_valid/a_address/a_data never change before the handshake; all data is correct.
REQ-038 stop_i 3 cycles into a memcpy of len 256 -> no new A requests after the stop; return to IDLE once responses drain; done_o stays 0.
REQ-039 d_error on the second read of a memcpy -> err_o=1 stays set until the next start_i; FSM returns to IDLE.
REQ-040 Chain build, two descriptors (memset len 8 -> memcpy len 8, next 0) -> both execute; done_o pulses exactly once. Length-0 descriptor -> no data requests; done_o pulses.
